gmii_tx_framer: RTL

Transmit framer placed directly downstream of the 2-to-1 interface selector in the 1G MAC transmit path. It accepts the selected byte stream (one byte per cycle while write is high, one frame per contiguous write burst), buffers it in a small FIFO, and drives GMII TX. On GMII it prepends the 7-byte preamble and the SFD, enforces the inter-frame gap, and flags FIFO overflow and underrun.

---
 rtl/gmii_tx_framer_if.sv | 31 +++
 rtl/gmii_tx_framer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer_if.sv
// Byte-stream input and GMII transmit bundle for gmii_tx_framer.
// Latency: none (wires only).
// Backpressure: none; the input side has no ready, so the framer drops bytes when full.
interface gmii_tx_framer_if #(
    parameter int FIFO_DEPTH = 64
) ();
    localparam int UW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    iv_data;
    logic          i_data_wr;
    logic [7:0]    ov_gmii_txd;
    logic          o_gmii_tx_en;
    logic          o_gmii_tx_er;
    logic          o_overflow;
    logic          o_underrun;
    logic [UW-1:0] ov_fifo_usedw;

    // Upstream selector side: produces bytes, observes the framer.
    modport master (
        output iv_data, i_data_wr,
        input  ov_gmii_txd, o_gmii_tx_en, o_gmii_tx_er,
        input  o_overflow, o_underrun, ov_fifo_usedw
    );

    // Framer side: consumes bytes, drives GMII and status.
    modport slave (
        input  iv_data, i_data_wr,
        output ov_gmii_txd, o_gmii_tx_en, o_gmii_tx_er,
        output o_overflow, o_underrun, ov_fifo_usedw
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: buffers a byte stream, adds preamble/SFD, enforces the inter-frame gap.
// Latency: 11 cycles from input byte to GMII byte for a gap-free frame; all outputs registered.
// Backpressure: none; a push into a full FIFO drops the byte and sets sticky o_overflow.
module gmii_tx_framer #(
    parameter int FIFO_DEPTH = 64,
    parameter int IFG_BYTES  = 12
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    gmii_tx_framer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = AW + 1;
    localparam int IW = (IFG_BYTES > 2) ? $clog2(IFG_BYTES) : 1;

    localparam logic [UW-1:0] FULL_CNT = UW'(FIFO_DEPTH);
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_BYTES - 1);
    localparam logic [2:0]    PRE_LAST = 3'd6;
    localparam logic [7:0]    PRE_BYTE = 8'h55;
    localparam logic [7:0]    SFD_BYTE = 8'hD5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_IFG  = 3'd4;

    typedef struct packed {
        logic       last;
        logic [7:0] dat;
    } entry_t;

    // Hold stage and FIFO bookkeeping
    logic          hold_vld_q, hold_vld_d;
    logic [7:0]    hold_dat_q, hold_dat_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [UW-1:0] usedw_q, usedw_d;
    logic          ovf_q, ovf_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        rd_ent;
    logic          push_ok;
    logic          push_last;
    logic          pop;

    // Transmit FSM and registered GMII outputs
    logic [2:0]    state_q, state_d;
    logic [2:0]    pre_cnt_q, pre_cnt_d;
    logic [IW-1:0] ifg_cnt_q, ifg_cnt_d;
    logic          term_q, term_d;
    logic [7:0]    txd_q, txd_d;
    logic          en_q, en_d;
    logic          er_q, er_d;
    logic          udr_q, udr_d;
    logic          go_start;
    logic          go_fetch;

    assign rd_ent = mem_q[rd_ptr_q];

    // Hold one byte so its last flag can be decided from the following cycle's write strobe
    always_comb begin
        hold_vld_d = bus.i_data_wr;
        hold_dat_d = bus.i_data_wr ? bus.iv_data : hold_dat_q;
        push_last  = ~bus.i_data_wr;
        // Room is judged on the registered count only; a same-cycle pop does not help.
        push_ok    = hold_vld_q && (usedw_q != FULL_CNT);
        ovf_d      = ovf_q | (hold_vld_q & ~push_ok);
        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        case ({push_ok, pop})
            2'b10:   usedw_d = usedw_q + UW'(1);
            2'b01:   usedw_d = usedw_q - UW'(1);
            default: usedw_d = usedw_q;
        endcase
    end

    // Next-state and next-output logic; the state names the byte currently on GMII,
    // so each decision here chooses the byte for the following cycle.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        ifg_cnt_d = ifg_cnt_q;
        term_d    = term_q;
        txd_d     = 8'h00;
        en_d      = 1'b0;
        er_d      = 1'b0;
        udr_d     = 1'b0;
        pop       = 1'b0;
        go_start  = 1'b0;
        go_fetch  = 1'b0;

        case (state_q)
            ST_IDLE: go_start = 1'b1;
            ST_PRE: begin
                en_d = 1'b1;
                if (pre_cnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    txd_d   = SFD_BYTE;
                end else begin
                    pre_cnt_d = pre_cnt_q + 3'd1;
                    txd_d     = PRE_BYTE;
                end
            end
            ST_SFD: go_fetch = 1'b1;
            ST_DATA: begin
                if (term_q) begin
                    state_d   = ST_IFG;
                    ifg_cnt_d = '0;
                end else begin
                    go_fetch = 1'b1;
                end
            end
            ST_IFG: begin
                // The last gap cycle also acts as IDLE so the gap is exactly IFG_BYTES long.
                if (ifg_cnt_q == IFG_LAST) begin
                    go_start = 1'b1;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_start) begin
            if (usedw_q != '0) begin
                state_d   = ST_PRE;
                pre_cnt_d = 3'd0;
                en_d      = 1'b1;
                txd_d     = PRE_BYTE;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (go_fetch) begin
            state_d = ST_DATA;
            en_d    = 1'b1;
            if (usedw_q != '0) begin
                pop    = 1'b1;
                txd_d  = rd_ent.dat;
                term_d = rd_ent.last;
            end else begin
                // Starved mid-frame: poison the frame and close it.
                er_d   = 1'b1;
                udr_d  = 1'b1;
                term_d = 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= '{last: push_last, dat: hold_dat_q};
        end
    end

    // State, pointer and output registers; reset aborts any frame and empties the FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_vld_q <= 1'b0;
            hold_dat_q <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= ST_IDLE;
            pre_cnt_q  <= 3'd0;
            ifg_cnt_q  <= '0;
            term_q     <= 1'b0;
            txd_q      <= 8'h00;
            en_q       <= 1'b0;
            er_q       <= 1'b0;
            udr_q      <= 1'b0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_dat_q <= hold_dat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usedw_q    <= usedw_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            ifg_cnt_q  <= ifg_cnt_d;
            term_q     <= term_d;
            txd_q      <= txd_d;
            en_q       <= en_d;
            er_q       <= er_d;
            udr_q      <= udr_d;
        end
    end

    assign bus.ov_gmii_txd   = txd_q;
    assign bus.o_gmii_tx_en  = en_q;
    assign bus.o_gmii_tx_er  = er_q;
    assign bus.o_overflow    = ovf_q;
    assign bus.o_underrun    = udr_q;
    assign bus.ov_fifo_usedw = usedw_q;
endmodule
